// File: rtl/pwm_pkg.sv
// Shared constants for the pwm_n pulse-width modulator slice.
package pwm_pkg;

  localparam int PWM_N_DEFAULT = 8;

  // Width of the shadow-register pair (duty + period) for a given counter width.
  function automatic int pwm_shadow_bits(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/pwm_n_if.sv
// Control/output bundle for pwm_n: programmed duty and period in, waveform out.
interface pwm_n_if
  import pwm_pkg::*;
#(
  parameter int N = PWM_N_DEFAULT
);

  logic [N-1:0] duty;
  logic [N-1:0] period;
  logic         pwm;

  modport master (
    output duty,
    output period,
    input  pwm
  );

  modport slave (
    input  duty,
    input  period,
    output pwm
  );

endinterface

// File: rtl/pwm_counter.sv
// N-bit counter that wraps to zero after reaching limit, with a boundary strobe
// and a shadow-load enable that also fires during clr.
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int N = PWM_N_DEFAULT
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [N-1:0] limit,
  output logic [N-1:0] cnt,
  output logic         wrap,
  output logic         load
);

  logic [N-1:0] cnt_r;
  logic         wrap_s;

  assign wrap_s = (cnt_r == limit);

  // Phase counter: clr aborts the cycle, otherwise advance or wrap at limit.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= {N{1'b0}};
    end else if (wrap_s) begin
      cnt_r <= {N{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(N-1){1'b0}}, 1'b1};
    end
  end

  assign cnt  = cnt_r;
  assign wrap = wrap_s;
  assign load = clr | wrap_s;

endmodule

// File: rtl/pwm_n.sv
// N-bit PWM: duty/period are shadowed at cycle boundaries so a mid-cycle
// update can never produce a runt pulse; output is a single flop.
module pwm_n
  import pwm_pkg::*;
#(
  parameter int N = PWM_N_DEFAULT
) (
  input  logic      clk,
  input  logic      clr,
  pwm_n_if.slave    bus
);

  logic [N-1:0] cnt_s;
  logic         wrap_s;
  logic         load_s;
  logic [N-1:0] duty_r;
  logic [N-1:0] period_r;
  logic         pwm_r;
  logic         high_s;

  pwm_counter #(
    .N (N)
  ) u_counter (
    .clk   (clk),
    .clr   (clr),
    .limit (period_r),
    .cnt   (cnt_s),
    .wrap  (wrap_s),
    .load  (load_s)
  );

  assign high_s = (cnt_s < duty_r);

  // Shadow registers: sample the requested duty/period on reset or at a boundary.
  always_ff @(posedge clk) begin
    if (load_s) begin
      duty_r   <= bus.duty;
      period_r <= bus.period;
    end else begin
      duty_r   <= duty_r;
      period_r <= period_r;
    end
  end

  // Output flop: one clock behind the counter phase it reflects.
  always_ff @(posedge clk) begin
    if (clr) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= high_s;
    end
  end

  assign bus.pwm = pwm_r;

endmodule

// File: tb/tb_pwm_n.sv
// Scoreboard bench for pwm_n: a per-cycle waveform model queues expected bits,
// a monitor pops and compares them one clock edge at a time.
module tb_pwm_n;
  import pwm_pkg::*;

  localparam int N = PWM_N_DEFAULT;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  pwm_n_if #(.N(N)) bus ();

  pwm_n #(.N(N)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  bit sb[$];
  bit wave[$];
  int vectors = 0;
  int miscompares = 0;
  bit mon_exp;

  // Whole waveform of one PWM cycle for the given duty/period.
  task automatic build_cycle(input int d, input int p);
    wave.delete();
    for (int i = 0; i <= p; i++) wave.push_back(i < d);
  endtask

  // Drive one clock of inputs and queue the value pwm must show after that edge.
  task automatic step(input bit c, input int d, input int p);
    bit e;
    @(negedge clk);
    clr        = c;
    bus.duty   = d[N-1:0];
    bus.period = p[N-1:0];
    if (c) begin
      e = 1'b0;
      build_cycle(d, p);
    end else begin
      e = wave.pop_front();
      if (wave.size() == 0) build_cycle(d, p);
    end
    sb.push_back(e);
  endtask

  task automatic hold(input bit c, input int d, input int p, input int n);
    for (int k = 0; k < n; k++) step(c, d, p);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        vectors++;
        if (bus.pwm !== mon_exp) begin
          miscompares++;
          $display("FAIL pwm vec %0d t=%0t: got %b expected %b", vectors, $time, bus.pwm, mon_exp);
        end
      end
    end
  end

  initial begin
    clr        = 1'b1;
    bus.duty   = '0;
    bus.period = '0;

    // Reset with duty 100, period 255, then three full cycles.
    hold(1'b1, 100, 255, 3);
    hold(1'b0, 100, 255, 768);

    // Duty sweep on a 256-clock cycle.
    for (int d = 0; d <= 252; d += 3) hold(1'b0, d, 255, 256);
    hold(1'b0, 254, 255, 256);
    hold(1'b0, 255, 255, 512);

    // Shadow timing: duty 3 -> 7 at cnt=5 of a period-9 cycle.
    hold(1'b1, 3, 9, 1);
    hold(1'b0, 3, 9, 25);
    hold(1'b0, 7, 9, 30);

    // Edge values.
    hold(1'b0, 10, 9, 30);
    hold(1'b0, 9, 9, 30);
    hold(1'b0, 1, 0, 10);
    hold(1'b0, 0, 0, 10);
    hold(1'b0, 1, 0, 5);

    // Reset mid-cycle at cnt=11, period 15, duty 8.
    hold(1'b1, 8, 15, 1);
    hold(1'b0, 8, 15, 27);
    hold(1'b1, 8, 15, 1);
    hold(1'b0, 8, 15, 48);

    // Period 15 -> 3 mid-cycle, duty 2.
    hold(1'b0, 2, 15, 5);
    hold(1'b0, 2, 3, 40);

    // Random segments: mostly short periods, occasional full range and resets.
    for (int s = 0; s < 300; s++) begin
      int d;
      int p;
      bit c;
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, 255);
        d = $urandom_range(0, 255);
      end else begin
        p = $urandom_range(0, 15);
        d = $urandom_range(0, 18);
      end
      c = ($urandom_range(0, 19) == 0);
      if (c) hold(1'b1, d, p, $urandom_range(1, 2));
      hold(1'b0, d, p, $urandom_range(1, 40));
    end

    @(posedge clk);
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_n.md
Name: pwm_n

Overview:
- Parameterised N-bit pulse-width modulator producing one output line with programmable period and duty.
- A free-running counter is compared against a duty value.
- Duty and period are sampled into shadow registers only at PWM-cycle boundaries, so updates never produce runt or glitched pulses.
- Used as a leaf peripheral: LED dimming, motor and DAC drive.

Parameters:
N, 8, width of counter, duty, period and shadow registers

Ports:
clk     input   1   system clock; all state updates on rising edge
clr     input   1   synchronous, active-high reset
duty    input   N   requested high time, in clocks per PWM cycle
period  input   N   requested PWM cycle length minus one (cycle = period+1 clocks)
pwm     output  1   registered PWM waveform

Behaviour:
- One clock domain (clk); reset clr is synchronous and active-high; no asynchronous reset anywhere.
- Internal state:
  - cnt[N-1:0]
  - duty_s[N-1:0], period_s[N-1:0] (shadow copies)
  - pwm register
- Reset (clr=1 at a rising edge):
  - cnt<=0, pwm<=0
  - duty_s<=duty, period_s<=period (inputs captured during reset)
  - clr has priority over all other activity, including mid-cycle: the cycle is aborted and restarts from cnt=0.
- Counter:
  - If cnt==period_s: cnt<=0, and in the same edge duty_s<=duty, period_s<=period (boundary load).
  - Otherwise cnt<=cnt+1.
  - cnt never exceeds period_s.
  - N-bit unsigned arithmetic; no carry beyond N bits is needed since cnt<=period_s<=2^N-1.
- Output: pwm<=(cnt<duty_s), unsigned compare, evaluated on current register values.
  - Fixed one-clock latency relative to cnt.
  - pwm driven only by a flop, so it is glitch-free.
- Cycle: exactly period_s+1 clocks; pwm is high for min(duty_s, period_s+1) clocks of each cycle.
- Boundary conditions:
  - duty_s==0: pwm constantly 0.
  - duty_s>period_s: pwm constantly 1.
  - duty_s==period_s: high period_s clocks, low 1 clock.
  - period_s==0: cycle length 1; cnt stays 0; pwm=1 iff duty_s!=0; inputs re-sampled every clock.
  - period=2^N-1 (255 for N=8): cycle = 2^N clocks; max duty 255 gives 255/256 high.
- Input changes:
  - duty/period changes mid-cycle have no effect until the next boundary (cnt==period_s edge).
  - A change on the exact boundary clock is captured at that edge.
- After clr deasserts: first edge yields pwm=(0<duty_s); waveform starts at cnt=0 phase.
- No X propagation: all registers are defined after one reset edge.

Decomposition:
- Shared package pwm_pkg: default width constant PWM_N_DEFAULT=8.
- Optional sub-module pwm_counter (N-bit wrap-at-limit counter with boundary strobe and shadow-load enable); comparator and shadow registers stay in pwm_n.
- No FSM required beyond counter/shadow logic.

Test Plan:
- Reset: clr=1 for 3 clocks with duty=100, period=255 -> pwm=0 throughout reset; after release, pwm rises on first edge, stays high 100 clocks, then low 156 clocks; repeats every 256 clocks.
- Sweep, N=8, period=255: step duty 0..254, one step every 256 clocks (aligned to cycle) -> each cycle's high count equals the duty value; duty=0 gives pwm constantly 0.
- Shadow timing: period=9, duty=3; change duty to 7 at cnt=5 -> current cycle finishes with 3 high / 7 low; next cycle shows 7 high / 3 low; no runt pulse.
- Edge values, period=9:
  - duty=10 -> pwm constantly 1.
  - duty=9 -> 9 high / 1 low.
  - period=0, duty=1 -> constantly 1.
  - period=0, duty=0 -> constantly 0.
- Reset mid-cycle: period=15, duty=8; assert clr for 1 clock at cnt=11 -> pwm=0 on the reset edge; next cycle starts at cnt=0 with a full 8-high / 8-low waveform.
- Period change: period 15->3 mid-cycle with duty=2 -> current 16-clock cycle completes; then 4-clock cycles with 2 high / 2 low.
